// File: rtl/game_pkg.sv
// Shared types and constants for the maze game-flow sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPlay  = 3'd1,
    StHit   = 3'd2,
    StClear = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [3:0]  StartKeyDefault = 4'd0;
  localparam int unsigned LevelW          = 2;
  localparam int unsigned LivesW          = 2;
  localparam int unsigned BlinkBit        = 6;

  function automatic logic [LivesW-1:0] sat_dec(input logic [LivesW-1:0] v);
    return (v == '0) ? v : v - 1'b1;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Dwell counter for HIT/CLEAR: clears on entry, counts while enabled, flags HOLD-1.
module hold_timer
  import game_pkg::*;
#(
  parameter int unsigned HOLD = 512,
  parameter int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc,
  output logic blink_nxt
);

  localparam logic [CntW-1:0] Last   = CntW'(HOLD - 1);
  localparam int unsigned     BitIdx = (CntW > BlinkBit) ? BlinkBit : 0;

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  // Next-count bit lets the FSM register blank in step with the counter.
  assign blink_nxt = (CntW > BlinkBit) ? cnt_d[BitIdx] : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_ctrl.sv
// Game-flow sequencer: gates dot motion, tracks lives and level, blinks on hit.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned LIVES      = 3,
  parameter int unsigned NUM_LEVELS = 4,
  parameter int unsigned HOLD       = 512,
  parameter logic [3:0]  START_KEY  = StartKeyDefault
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        keycode,
  input  logic              coll,
  input  logic              at_goal,
  output logic              move_en,
  output logic              dot_home,
  output logic [LevelW-1:0] level,
  output logic [LivesW-1:0] lives,
  output logic              blank,
  output logic              win,
  output logic              game_over
);

  localparam logic [LevelW-1:0] LastLevel  = LevelW'(NUM_LEVELS - 1);
  localparam logic [LivesW-1:0] StartLives = LivesW'(LIVES);

  state_e            state_q, state_d;
  logic [LevelW-1:0] level_q, level_d;
  logic [LivesW-1:0] lives_q, lives_d;
  logic              move_en_q, move_en_d;
  logic              dot_home_q, dot_home_d;
  logic              blank_q, blank_d;
  logic              win_q, win_d;
  logic              game_over_q, game_over_d;

  logic hold_clr, hold_en, hold_tc, blink_nxt;
  logic start_key;

  hold_timer #(
    .HOLD (HOLD)
  ) u_hold_timer (
    .clk       (clk),
    .reset     (reset),
    .clr       (hold_clr),
    .en        (hold_en),
    .tc        (hold_tc),
    .blink_nxt (blink_nxt)
  );

  assign start_key = key_valid && (keycode == START_KEY);
  assign hold_en   = (state_q == StHit) || (state_q == StClear);

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    lives_d     = lives_q;
    win_d       = win_q;
    game_over_d = game_over_q;
    hold_clr    = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_key) begin
          state_d     = StPlay;
          level_d     = '0;
          lives_d     = StartLives;
          win_d       = 1'b0;
          game_over_d = 1'b0;
        end
      end
      StPlay: begin
        // Position reload lands this cycle, so coll/at_goal are still stale.
        if (!dot_home_q) begin
          if (coll) begin
            state_d  = StHit;
            lives_d  = sat_dec(lives_q);
            hold_clr = 1'b1;
          end else if (at_goal) begin
            state_d  = StClear;
            hold_clr = 1'b1;
          end
        end
      end
      StHit: begin
        if (hold_tc) begin
          if (lives_q == '0) begin
            state_d     = StDone;
            game_over_d = 1'b1;
          end else begin
            state_d = StPlay;
          end
        end
      end
      StClear: begin
        if (hold_tc) begin
          if (level_q >= LastLevel) begin
            state_d = StDone;
            win_d   = 1'b1;
          end else begin
            state_d = StPlay;
            level_d = level_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    move_en_d  = (state_d == StPlay);
    dot_home_d = (state_d == StPlay) && (state_q != StPlay);
    blank_d    = (state_d == StHit) && blink_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      level_q     <= '0;
      lives_q     <= StartLives;
      move_en_q   <= 1'b0;
      dot_home_q  <= 1'b0;
      blank_q     <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      move_en_q   <= move_en_d;
      dot_home_q  <= dot_home_d;
      blank_q     <= blank_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
    end
  end

  assign move_en   = move_en_q;
  assign dot_home  = dot_home_q;
  assign level     = level_q;
  assign lives     = lives_q;
  assign blank     = blank_q;
  assign win       = win_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: expectations queued per step, checked after the edge.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] keycode = 4'd0;
  logic       coll = 1'b0;
  logic       at_goal = 1'b0;
  logic       move_en, dot_home, blank, win, game_over;
  logic [1:0] level, lives;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [8:0] val;
  } exp_t;

  exp_t sb[$];

  game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .keycode   (keycode),
    .coll      (coll),
    .at_goal   (at_goal),
    .move_en   (move_en),
    .dot_home  (dot_home),
    .level     (level),
    .lives     (lives),
    .blank     (blank),
    .win       (win),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mk(input bit me, input bit dh, input logic [1:0] lv,
                                    input logic [1:0] li, input bit bl, input bit wn,
                                    input bit go);
    return {me, dh, lv, li, bl, wn, go};
  endfunction

  function automatic logic [8:0] outs();
    return {move_en, dot_home, level, lives, blank, win, game_over};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fields in hex: {move_en,dot_home,level[1:0],lives[1:0],blank,win,game_over}.
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq(e.tag, 32'(outs()), 32'(e.val));
    end
  end

  task automatic step(input bit kv, input logic [3:0] kc, input bit c, input bit g);
    @(negedge clk);
    key_valid = kv;
    keycode   = kc;
    coll      = c;
    at_goal   = g;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [8:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    idle(1);                  expect_out("reset_vals", mk(0, 0, 0, 3, 0, 0, 0));
    step(1, 4'd5, 0, 0);      expect_out("idle_key5", mk(0, 0, 0, 3, 0, 0, 0));
    step(1, 4'd0, 0, 0);      expect_out("start", mk(1, 1, 0, 3, 0, 0, 0));
    idle(1);                  expect_out("play", mk(1, 0, 0, 3, 0, 0, 0));

    // First hit: full dwell with blink phases.
    step(0, 4'd0, 1, 0);      expect_out("hit1_entry", mk(0, 0, 0, 2, 0, 0, 0));
    idle(63);                 expect_out("blank_c63", mk(0, 0, 0, 2, 0, 0, 0));
    idle(1);                  expect_out("blank_c64", mk(0, 0, 0, 2, 1, 0, 0));
    idle(64);                 expect_out("blank_c128", mk(0, 0, 0, 2, 0, 0, 0));
    idle(383);                expect_out("hit1_end", mk(0, 0, 0, 2, 1, 0, 0));
    idle(1);                  expect_out("hit1_recover", mk(1, 1, 0, 2, 0, 0, 0));

    // Events in the first PLAY cycle after dot_home are ignored; then coll beats at_goal.
    step(0, 4'd0, 1, 1);      expect_out("first_cycle_ign", mk(1, 0, 0, 2, 0, 0, 0));
    step(0, 4'd0, 1, 1);      expect_out("both_hit", mk(0, 0, 0, 1, 0, 0, 0));
    idle(511);                expect_out("hit2_end", mk(0, 0, 0, 1, 1, 0, 0));
    idle(1);                  expect_out("hit2_recover", mk(1, 1, 0, 1, 0, 0, 0));
    idle(1);                  expect_out("play2", mk(1, 0, 0, 1, 0, 0, 0));
    step(1, 4'd0, 0, 0);      expect_out("start_in_play", mk(1, 0, 0, 1, 0, 0, 0));

    // Last life lost.
    step(0, 4'd0, 1, 0);      expect_out("hit3_entry", mk(0, 0, 0, 0, 0, 0, 0));
    idle(511);                expect_out("hit3_end", mk(0, 0, 0, 0, 1, 0, 0));
    idle(1);                  expect_out("game_over", mk(0, 0, 0, 0, 0, 0, 1));
    step(1, 4'd5, 0, 0);      expect_out("done_key5", mk(0, 0, 0, 0, 0, 0, 1));
    step(1, 4'd0, 0, 0);      expect_out("restart", mk(1, 1, 0, 3, 0, 0, 0));
    idle(1);

    // Level progression.
    for (int lv = 0; lv < 3; lv++) begin
      step(0, 4'd0, 0, 1);    expect_out("clr_entry", mk(0, 0, 2'(lv), 3, 0, 0, 0));
      idle(100);              expect_out("clr_noblank", mk(0, 0, 2'(lv), 3, 0, 0, 0));
      idle(411);              expect_out("clr_end", mk(0, 0, 2'(lv), 3, 0, 0, 0));
      idle(1);                expect_out("level_up", mk(1, 1, 2'(lv + 1), 3, 0, 0, 0));
      idle(1);
    end
    step(0, 4'd0, 0, 1);      expect_out("clr3_entry", mk(0, 0, 3, 3, 0, 0, 0));
    idle(511);                expect_out("clr3_end", mk(0, 0, 3, 3, 0, 0, 0));
    idle(1);                  expect_out("win", mk(0, 0, 3, 3, 0, 1, 0));
    idle(3);                  expect_out("win_hold", mk(0, 0, 3, 3, 0, 1, 0));
    step(1, 4'd0, 0, 0);      expect_out("restart_win", mk(1, 1, 0, 3, 0, 0, 0));
    idle(1);

    // Reset in the middle of a hit, at count 300.
    step(0, 4'd0, 1, 0);      expect_out("hit4_entry", mk(0, 0, 0, 2, 0, 0, 0));
    idle(300);
    #3;
    reset = 1'b1;
    #1;
    check_eq("mid_reset", 32'(outs()), 32'(mk(0, 0, 0, 3, 0, 0, 0)));
    @(negedge clk);
    reset = 1'b0;
    step(1, 4'd0, 0, 0);      expect_out("post_rst_start", mk(1, 1, 0, 3, 0, 0, 0));
    idle(1);
    step(0, 4'd0, 1, 0);      expect_out("hit5_entry", mk(0, 0, 0, 2, 0, 0, 0));
    idle(511);                expect_out("hit5_end", mk(0, 0, 0, 2, 1, 0, 0));
    idle(1);                  expect_out("hit5_recover", mk(1, 1, 0, 2, 0, 0, 0));

    @(posedge clk);
    #2;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Game-flow sequencer for the 8x8 LED red-dot maze. Sits between the keypad path (debounced scancode buffer) and the dot-motion, collision and map blocks. Decides when the dot may move, when it returns to its start square, and which maze level the map ROM shows. Tracks lives, drives a blink/blank signal for the display mixer on hit, and holds win/game-over status.

## Interface
- `LIVES`, default 3: lives at game start, range 1..3.
- `NUM_LEVELS`, default 4: maze levels, range 1..4.
- `HOLD`, default 512: cycles the block stays in HIT or CLEAR before moving on.
- `START_KEY`, default 4'd0: keycode that starts or restarts a game.
- `clk`, input, 1: the single clock (the divided scan tick domain).
- `reset`, input, 1: asynchronous, active-high.
- `key_valid`, input, 1: one-cycle pulse; `keycode` is valid in that cycle.
- `keycode`, input, 4: buffered key code.
- `coll`, input, 1: dot overlaps a wall (level signal).
- `at_goal`, input, 1: dot is on the goal square (level signal).
- `move_en`, output, 1: motion block may act on keys.
- `dot_home`, output, 1: one-cycle pulse; motion block reloads the start position.
- `level`, output, 2: map select, which extends the map ROM address.
- `lives`, output, 2: remaining lives.
- `blank`, output, 1: display mixer suppresses red when high.
- `win`, output, 1: all levels cleared.
- `game_over`, output, 1: lives exhausted.

## Operation
- The FSM has five states: IDLE, PLAY, HIT, CLEAR, DONE.
- **Reset values:** state IDLE, `level` 0, `lives` = LIVES, hold counter 0, and all 1-bit outputs 0.
- **IDLE:** `move_en` is 0.
  - `key_valid` with keycode == START_KEY: set `level` to 0 and `lives` to LIVES, pulse `dot_home`, go to PLAY.
  - All other keys are ignored.
- **PLAY:** `move_en` is 1.
  - `coll` = 1: go to HIT.
  - Otherwise `at_goal` = 1: go to CLEAR.
  - Both high in the same cycle: `coll` wins.
- **HIT:** `move_en` is 0 and `blank` = hold counter bit 6, so the dot blinks.
  - On entry, `lives` decrements. The decrement saturates at 0 and never wraps.
  - After HOLD cycles, if `lives` = 0: go to DONE with `game_over` = 1.
  - Otherwise: pulse `dot_home` and return to PLAY.
- **CLEAR:** `move_en` is 0 and `blank` is 0.
  - After HOLD cycles, if `level` = NUM_LEVELS-1: go to DONE with `win` = 1.
  - Otherwise: increment `level`, pulse `dot_home`, go to PLAY.
  - `level` never exceeds NUM_LEVELS-1.
- **DONE:** `move_en` is 0. `win` or `game_over` holds.
  - START_KEY clears both flags and restarts exactly as from IDLE.
- Keys other than START_KEY affect this block only in IDLE and DONE, where they are ignored. Key movement is the motion block's job.
- START_KEY during PLAY, HIT or CLEAR is ignored.
- Asserting `reset` mid-game returns to IDLE immediately with all reset values.

## Timing
- All outputs are registered.
- A state change appears on outputs one clock after the qualifying input is sampled.
- `coll` or `at_goal` sampled high at edge N gives `move_en` = 0 after edge N. The motion block may therefore take at most one more step.
- `dot_home` is high for exactly one cycle, the cycle after leaving IDLE, DONE, HIT or CLEAR. `move_en` rises in that same cycle. The motion block gives reload priority over a key.
- The hold counter clears on entry to HIT or CLEAR. The exit decision is taken at count HOLD-1, so dwell is exactly HOLD cycles.
- The collision detector needs the reloaded position before PLAY samples `coll`. `coll` and `at_goal` are therefore ignored in the first PLAY cycle after a `dot_home` pulse.
- `level` changes in the same cycle as `dot_home`, so map and position update together.

## Structure
- The shared package `game_pkg` holds:
  - the state encoding: IDLE=0, PLAY=1, HIT=2, CLEAR=3, DONE=4, 3 bits;
  - the START_KEY default;
  - the level width (2).
- One sub-module, `hold_timer`: a counter with `clr`/`en` inputs and a terminal-count output at HOLD-1, width clog2(HOLD).
- Everything else stays in the FSM.

## Test plan
- **Reset and start:** reset, then START_KEY → after reset `level`=0, `lives`=3, `move_en`=0. The cycle after the key gives `dot_home`=1 for exactly 1 cycle and `move_en`=1. Keycode 4'd5 while in IDLE gives no change.
- **Hit and recovery:** PLAY, `coll` pulsed → `move_en`=0 next cycle and `lives`=2. `blank` toggles every 64 cycles. After 512 cycles, `dot_home` pulses and `move_en`=1.
- **Game over:** three collisions → `lives`=0, DONE, `game_over`=1. START_KEY then restores `lives`=3, `level`=0 and clears `game_over`.
- **Level progression and win:** `at_goal` in levels 0..2 → `level` steps 1, 2, 3 after each 512-cycle hold. `at_goal` in level 3 → `win`=1 and `level` stays at 3.
- **Simultaneous events:** `coll` and `at_goal` high together → HIT taken and `level` unchanged. Both high in the first cycle after `dot_home` → ignored.
- **Reset mid-operation:** `reset` during HIT at count 300 → outputs return to reset values at once. The next START begins a clean game with a full 512-cycle hold on the next hit.
